// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares the single data RAM between the CPU data port (requester 0) and a
//   second bus master (requester 1). Each transfer is a level request that is
//   granted in IDLE, held in ACCESS for WAIT+1 cycles, and acknowledged with a
//   one-cycle pulse in DONE. Ties are broken round-robin against the last winner.
//
// Ports
//   clk               system clock, rising edge
//   res               asynchronous active-low reset
//   enable            1 = new grants allowed (in-flight access always completes)
//   req0/req1         level request, held until the matching ack
//   wr0/wr1           1 = write, 0 = read (sampled at grant)
//   addr0/addr1       12-bit word address (sampled at grant)
//   wdata0/wdata1     16-bit write data (sampled at grant)
//   rdata0/rdata1     read data per requester, held until its next completed read
//   ack0/ack1         one-cycle completion pulse
//   grant             one-hot owner in ACCESS/DONE, 00 in IDLE
//   busy              1 in ACCESS or DONE
//   dataAddr/dataOut  RAM address / write data (0 outside ACCESS)
//   dataIn            RAM read data
//   selData/ldData    RAM select / load (1 = read)
//   clrData           RAM clear, combinational ~res
//
// WAIT is the number of extra RAM cycles per access, legal range 0..7.

module ram_arbiter #(
  parameter int unsigned WAIT = 1
) (
  input  logic        clk,
  input  logic        res,
  input  logic        enable,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [11:0] addr0,
  input  logic [11:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [11:0] dataAddr,
  output logic [15:0] dataOut,
  input  logic [15:0] dataIn,
  output logic        selData,
  output logic        ldData,
  output logic        clrData
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(WAIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic        r_last;
  logic        r_owner;
  logic        r_wr;
  logic [11:0] r_addr;
  logic [15:0] r_wdata;

  logic        w_take;
  logic        w_winner;
  logic        w_owner_nxt;
  logic        w_wr_nxt;
  logic [11:0] w_addr_nxt;
  logic [15:0] w_wdata_nxt;
  logic        w_capture;

  logic [15:0] r_rdata0;
  logic [15:0] r_rdata1;
  logic        r_ack0;
  logic        r_ack1;
  logic [1:0]  r_grant;
  logic        r_busy;
  logic [11:0] r_daddr;
  logic [15:0] r_dout;
  logic        r_sel;
  logic        r_ld;

  logic        w_access_nxt;
  logic        w_busy_nxt;
  logic        w_sel_nxt;
  logic        w_ld_nxt;
  logic [11:0] w_daddr_nxt;
  logic [15:0] w_dout_nxt;
  logic        w_ack0_nxt;
  logic        w_ack1_nxt;
  logic [1:0]  w_grant_nxt;

  // State register: FSM state, wait counter, round-robin history, owner.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      if (w_take) begin
        r_cnt  <= CNT_LOAD;
        r_last <= w_winner;
      end else if (r_state == S_ACCESS && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // Transfer parameters latched at grant; only meaningful while busy.
  always_ff @(posedge clk) begin
    r_wr    <= w_wr_nxt;
    r_addr  <= w_addr_nxt;
    r_wdata <= w_wdata_nxt;
  end

  // Next-state logic. With both requesters high the one not served last wins.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_winner    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && (req0 || req1)) begin
          w_take      = 1'b1;
          w_state_nxt = S_ACCESS;
          w_winner    = (req0 && req1) ? ~r_last : req1;
        end
      end
      S_ACCESS: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic: every output except clrData is registered, so the values
  // are computed from the state being entered and the parameters it will hold.
  always_comb begin
    w_owner_nxt  = w_take ? w_winner : r_owner;
    w_wr_nxt     = w_take ? (w_winner ? wr1 : wr0) : r_wr;
    w_addr_nxt   = w_take ? (w_winner ? addr1 : addr0) : r_addr;
    w_wdata_nxt  = w_take ? (w_winner ? wdata1 : wdata0) : r_wdata;

    w_access_nxt = (w_state_nxt == S_ACCESS);
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    w_sel_nxt    = w_access_nxt;
    w_ld_nxt     = w_access_nxt && !w_wr_nxt;
    w_daddr_nxt  = w_access_nxt ? w_addr_nxt : 12'h000;
    w_dout_nxt   = (w_access_nxt && w_wr_nxt) ? w_wdata_nxt : 16'h0000;
    w_ack0_nxt   = (w_state_nxt == S_DONE) && !r_owner;
    w_ack1_nxt   = (w_state_nxt == S_DONE) &&  r_owner;
    w_grant_nxt  = w_busy_nxt ? (w_owner_nxt ? 2'b10 : 2'b01) : 2'b00;

    // Read data is taken on the edge that ends the last ACCESS cycle.
    w_capture    = (r_state == S_ACCESS) && (r_cnt == 3'd0) && !r_wr;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_rdata0 <= 16'h0000;
      r_rdata1 <= 16'h0000;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_grant  <= 2'b00;
      r_busy   <= 1'b0;
      r_daddr  <= 12'h000;
      r_dout   <= 16'h0000;
      r_sel    <= 1'b0;
      r_ld     <= 1'b0;
    end else begin
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
      r_daddr <= w_daddr_nxt;
      r_dout  <= w_dout_nxt;
      r_sel   <= w_sel_nxt;
      r_ld    <= w_ld_nxt;
      if (w_capture) begin
        if (r_owner) begin
          r_rdata1 <= dataIn;
        end else begin
          r_rdata0 <= dataIn;
        end
      end
    end
  end

  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;
  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign grant    = r_grant;
  assign busy     = r_busy;
  assign dataAddr = r_daddr;
  assign dataOut  = r_dout;
  assign selData  = r_sel;
  assign ldData   = r_ld;
  assign clrData  = ~res;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        enable = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [11:0] addr0 = 12'h0, addr1 = 12'h0;
  logic [15:0] wdata0 = 16'h0, wdata1 = 16'h0;
  logic [15:0] rdata0, rdata1, dataOut;
  logic [15:0] dataIn = 16'h0;
  logic        ack0, ack1, busy, selData, ldData, clrData;
  logic [1:0]  grant;
  logic [11:0] dataAddr;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.WAIT(W)) dut (
    .clk(clk), .res(res), .enable(enable),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(rdata0), .rdata1(rdata1), .ack0(ack0), .ack1(ack1),
    .grant(grant), .busy(busy), .dataAddr(dataAddr), .dataOut(dataOut),
    .dataIn(dataIn), .selData(selData), .ldData(ldData), .clrData(clrData)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [11:0] a);
    return (a == 12'h010) ? 16'hBEEF : {4'hC, a};
  endfunction

  // RAM behind the arbiter: unwritten words read their initial pattern.
  logic [15:0] ram   [0:4095];
  bit          ram_v [0:4095];
  always @(posedge clk) begin
    if (selData && !ldData) begin
      ram[dataAddr]   <= dataOut;
      ram_v[dataAddr] <= 1'b1;
    end
  end
  always @(negedge clk) dataIn <= ram_v[dataAddr] ? ram[dataAddr] : init_val(dataAddr);

  // Reference model: a transfer is "cycles left"; W+1 access cycles then one done cycle.
  int          m_left;
  logic        m_last, m_owner, m_wr;
  logic [11:0] m_addr;
  logic [15:0] m_wdata, m_rd0, m_rd1;
  logic [15:0] mmem   [0:4095];
  bit          mmem_v [0:4095];

  function automatic logic winner(input logic a, input logic b, input logic last);
    return (a && b) ? ~last : b;
  endfunction

  function automatic logic [15:0] mem_rd(input logic [11:0] a);
    return mmem_v[a] ? mmem[a] : init_val(a);
  endfunction

  always @(posedge clk or negedge res) begin
    if (!res) begin
      m_left <= 0; m_last <= 1'b1; m_owner <= 1'b0; m_rd0 <= 16'h0; m_rd1 <= 16'h0;
    end else if (m_left == 0) begin
      if (enable && (req0 || req1)) begin
        m_owner <= winner(req0, req1, m_last);
        m_last  <= winner(req0, req1, m_last);
        m_wr    <= winner(req0, req1, m_last) ? wr1 : wr0;
        m_addr  <= winner(req0, req1, m_last) ? addr1 : addr0;
        m_wdata <= winner(req0, req1, m_last) ? wdata1 : wdata0;
        m_left  <= W + 2;
      end
    end else begin
      if (m_left == 2) begin
        if (m_wr) begin
          mmem[m_addr] <= m_wdata; mmem_v[m_addr] <= 1'b1;
        end else if (m_owner) m_rd1 <= mem_rd(m_addr);
        else m_rd0 <= mem_rd(m_addr);
      end
      m_left <= m_left - 1;
    end
  end

  function automatic logic [67:0] model_vec();
    logic acc, dn;
    logic [1:0] g;
    acc = (m_left >= 2);
    dn  = (m_left == 1);
    g   = (m_left != 0) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    return {m_rd0, m_rd1, dn && !m_owner, dn && m_owner, g, m_left != 0,
            acc ? m_addr : 12'h000, (acc && m_wr) ? m_wdata : 16'h0000,
            acc, acc && !m_wr, ~res};
  endfunction

  wire [67:0] dut_vec = {rdata0, rdata1, ack0, ack1, grant, busy, dataAddr, dataOut,
                         selData, ldData, clrData};

  // Every cycle the full output set is compared with the model.
  initial forever begin
    @(negedge clk);
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, dut_vec, model_vec());
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (busy) ok = 1'b1;
    end
    if (!ok) chk("timeout_busy", 32'd0, 32'd1);
  endtask

  task automatic wait_ack(input bit who, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (who ? ack1 : ack0) ok = 1'b1;
    end
    if (!ok) chk("timeout_ack", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 res = 1'b0;
    @(negedge clk); #2 res = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic r0; logic w0; logic [11:0] a0; logic [15:0] d0;
    logic r1; logic w1; logic [11:0] a1; logic [15:0] d1;
    logic [1:0] eg; logic crd; logic [15:0] erd;
  } vec_t;

  vec_t vt [11];

  initial begin
    bit ok;
    int nsel, nld, nack, first, ack_at, ng, na, nrise;
    logic prev;
    logic [1:0] gseq [4];
    logic [1:0] aseq [4];
    int gidx [4];

    vt[0]  = '{1'b1, 1'b0, 12'h010, 16'h0,    1'b0, 1'b0, 12'h000, 16'h0,    2'b01, 1'b1, 16'hBEEF};
    vt[1]  = '{1'b1, 1'b0, 12'h020, 16'h0,    1'b1, 1'b0, 12'h030, 16'h0,    2'b10, 1'b1, 16'hC030};
    vt[2]  = '{1'b1, 1'b0, 12'h021, 16'h0,    1'b1, 1'b0, 12'h031, 16'h0,    2'b01, 1'b1, 16'hC021};
    vt[3]  = '{1'b0, 1'b0, 12'h000, 16'h0,    1'b1, 1'b1, 12'h100, 16'h5A5A, 2'b10, 1'b0, 16'h0};
    vt[4]  = '{1'b1, 1'b0, 12'h100, 16'h0,    1'b0, 1'b0, 12'h000, 16'h0,    2'b01, 1'b1, 16'h5A5A};
    vt[5]  = '{1'b0, 1'b0, 12'h000, 16'h0,    1'b1, 1'b0, 12'h0FF, 16'h0,    2'b10, 1'b1, 16'hC0FF};
    vt[6]  = '{1'b1, 1'b1, 12'h000, 16'hFFFF, 1'b0, 1'b0, 12'h000, 16'h0,    2'b01, 1'b0, 16'h0};
    vt[7]  = '{1'b1, 1'b0, 12'h000, 16'h0,    1'b1, 1'b0, 12'h100, 16'h0,    2'b10, 1'b1, 16'h5A5A};
    vt[8]  = '{1'b1, 1'b0, 12'h000, 16'h0,    1'b1, 1'b0, 12'h0FF, 16'h0,    2'b01, 1'b1, 16'hFFFF};
    vt[9]  = '{1'b1, 1'b1, 12'h200, 16'h0001, 1'b1, 1'b1, 12'h201, 16'h0002, 2'b10, 1'b0, 16'h0};
    vt[10] = '{1'b0, 1'b0, 12'h000, 16'h0,    1'b1, 1'b0, 12'h201, 16'h0,    2'b10, 1'b1, 16'h0002};

    // Reset values
    #2 res = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_clrData", {31'd0, clrData}, 32'd1);
    chk("rst_ctrl", {26'd0, grant, busy, ack0, ack1, selData, ldData}, 32'd0);
    chk("rst_addr_data", {4'd0, dataAddr, dataOut}, 32'd0);
    chk("rst_rdata", {rdata0, rdata1}, 32'd0);
    #2 res = 1'b1;
    @(negedge clk);
    chk("rel_clrData", {31'd0, clrData}, 32'd0);

    // Single read by requester 0
    req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h010;
    nsel = 0; nld = 0; nack = 0; first = -1; ack_at = -1;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      if (selData) nsel++;
      if (selData && ldData) nld++;
      if (selData && first < 0) first = i;
      if (ack0) begin nack++; ack_at = i; req0 = 1'b0; end
    end
    chk("rd_sel_cycles", nsel, W + 1);
    chk("rd_ld_cycles", nld, W + 1);
    chk("rd_ack0_pulses", nack, 1);
    chk("rd_ack_latency", ack_at - first, W + 1);
    chk("rd_rdata0", rdata0, 16'hBEEF);
    chk("rd_rdata1_untouched", rdata1, 16'h0000);

    // Write by requester 1 to the top address, then read back
    req1 = 1'b1; wr1 = 1'b1; addr1 = 12'hFFF; wdata1 = 16'h1234;
    wait_busy(ok);
    chk("wr_grant", grant, 2'b10);
    chk("wr_sel_ld", {selData, ldData}, 2'b10);
    chk("wr_dataAddr", dataAddr, 12'hFFF);
    chk("wr_dataOut", dataOut, 16'h1234);
    wait_ack(1'b1, ok);
    req1 = 1'b0; wr1 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 12'hFFF;
    wait_ack(1'b0, ok);
    req0 = 1'b0;
    chk("wr_readback", rdata0, 16'h1234);
    chk("wr_rdata1_untouched", rdata1, 16'h0000);

    // Table of single transactions; ties follow round-robin from reset
    do_reset();
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      req0 = vt[k].r0; wr0 = vt[k].w0; addr0 = vt[k].a0; wdata0 = vt[k].d0;
      req1 = vt[k].r1; wr1 = vt[k].w1; addr1 = vt[k].a1; wdata1 = vt[k].d1;
      wait_busy(ok);
      chk($sformatf("vec%0d_grant", k), grant, vt[k].eg);
      req0 = 1'b0; req1 = 1'b0;
      wait_ack(vt[k].eg == 2'b10, ok);
      chk($sformatf("vec%0d_ack", k), {ack1, ack0}, vt[k].eg);
      if (vt[k].crd)
        chk($sformatf("vec%0d_rdata", k), (vt[k].eg == 2'b10) ? rdata1 : rdata0, vt[k].erd);
    end

    // Contention: both held high after reset
    do_reset();
    req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h040;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 12'h041;
    prev = 1'b0; ng = 0; na = 0;
    for (int i = 0; i < 4; i++) begin gseq[i] = 2'b00; aseq[i] = 2'b00; gidx[i] = 0; end
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (busy && !prev && ng < 4) begin gseq[ng] = grant; gidx[ng] = i; ng++; end
      if ((ack0 || ack1) && na < 4) begin aseq[na] = {ack1, ack0}; na++; end
      prev = busy;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_ngrants", ng, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cont_grant%0d", i), gseq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("cont_ack%0d", i), aseq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk($sformatf("cont_spacing%0d", i), gidx[i] - gidx[i-1], W + 3);
    end
    repeat (W + 4) @(negedge clk);

    // Enable gating
    enable = 1'b0; req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h050;
    nsel = 0; nack = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) nsel++;
      if (ack0) nack++;
    end
    chk("en_busy_cycles", nsel, 0);
    chk("en_acks", nack, 0);
    enable = 1'b1;
    @(negedge clk);
    chk("en_grant_next_edge", {busy, grant}, 3'b101);
    wait_ack(1'b0, ok);
    req0 = 1'b0;
    chk("en_rdata0", rdata0, 16'hC050);

    // Reset during the second ACCESS cycle
    @(negedge clk);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h060;
    wait_busy(ok);
    @(posedge clk);
    #2 res = 1'b0;
    #1;
    chk("mid_rst_ctrl", {26'd0, grant, busy, ack0, ack1, selData, ldData}, 32'd0);
    chk("mid_rst_addr_data", {4'd0, dataAddr, dataOut}, 32'd0);
    chk("mid_rst_rdata0", rdata0, 16'h0000);
    chk("mid_rst_clrData", {31'd0, clrData}, 32'd1);
    @(negedge clk); #2 res = 1'b1;
    wait_busy(ok);
    chk("mid_rst_regrant", grant, 2'b01);
    wait_ack(1'b0, ok);
    req0 = 1'b0;
    chk("mid_rst_rdata0_after", rdata0, 16'hC060);

    // Request dropped during ACCESS
    @(negedge clk);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h070;
    wait_busy(ok);
    req0 = 1'b0;
    prev = 1'b1; nack = 0; nrise = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack0) nack++;
      if (busy && !prev) nrise++;
      prev = busy;
    end
    chk("drop_ack0_pulses", nack, 1);
    chk("drop_no_regrant", nrise, 0);
    chk("drop_rdata0", rdata0, 16'hC070);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 7) != 0);
      req0   = ($urandom_range(0, 2) != 0);
      req1   = ($urandom_range(0, 2) != 0);
      wr0    = $urandom_range(0, 1) == 1;
      wr1    = $urandom_range(0, 1) == 1;
      addr0  = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      addr1  = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      wdata0 = 16'($urandom);
      wdata1 = 16'($urandom);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
